// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks the destination registers of the in-flight instructions after decode
// and produces operand-forwarding selects plus a load-use stall for the decode-stage instruction.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   issue_valid/rd/regwrite/load  decode-stage instruction destination info
//   src_a/src_b, src_*_used       decode-stage source registers and read enables
//   flush                         kill the decode-stage instruction
//   stall                         hold PC and IF/ID, insert a bubble
//   fwd_a/fwd_b                   0 = regfile, k = forward from stage k
//   stall_cnt/fwd_cnt             statistics counters
//
// Optional feature: define HAZARD_SCOREBOARD_STATS_EN to build the saturating statistics
// counters; otherwise both counter outputs are tied to zero and no counter flops exist.
module hazard_scoreboard #(
  parameter int unsigned REG_BITS   = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned ZERO_REG   = 31,
  localparam int unsigned FW        = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [REG_BITS-1:0] issue_rd,
  input  logic                issue_regwrite,
  input  logic                issue_load,
  input  logic [REG_BITS-1:0] src_a,
  input  logic [REG_BITS-1:0] src_b,
  input  logic                src_a_used,
  input  logic                src_b_used,
  input  logic                flush,
  output logic                stall,
  output logic [FW-1:0]       fwd_a,
  output logic [FW-1:0]       fwd_b,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         fwd_cnt
);

  localparam logic [REG_BITS-1:0] ZeroReg = REG_BITS'(ZERO_REG);

  // Index i holds stage i+1 (EX, MEM, WB, ...).
  logic [DEPTH-1:0]               valid_q;
  logic [DEPTH-1:0][REG_BITS-1:0] rd_q;
  logic [DEPTH-1:0]               regwrite_q;
  logic [DEPTH-1:0]               load_q;

  logic hazard_a;
  logic hazard_b;
  logic issue_accept;

  // Scan oldest to youngest so the youngest matching producer overwrites older ones.
  always_comb begin
    fwd_a    = '0;
    fwd_b    = '0;
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && regwrite_q[i] && (rd_q[i] != ZeroReg) &&
          (rd_q[i] == src_a) && src_a_used) begin
        fwd_a    = FW'(i + 1);
        // Load data is not yet available before LOAD_STAGE.
        hazard_a = load_q[i] && ((i + 1) < int'(LOAD_STAGE));
      end
      if (valid_q[i] && regwrite_q[i] && (rd_q[i] != ZeroReg) &&
          (rd_q[i] == src_b) && src_b_used) begin
        fwd_b    = FW'(i + 1);
        hazard_b = load_q[i] && ((i + 1) < int'(LOAD_STAGE));
      end
    end
  end

  // Flush outranks stall: a killed instruction never stalls.
  assign stall        = (hazard_a || hazard_b) && issue_valid && !flush;
  assign issue_accept = issue_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    for (int i = DEPTH - 1; i > 0; i--) begin
      valid_q[i]    <= valid_q[i-1];
      rd_q[i]       <= rd_q[i-1];
      regwrite_q[i] <= regwrite_q[i-1];
      load_q[i]     <= load_q[i-1];
    end
    valid_q[0]    <= issue_accept;
    rd_q[0]       <= issue_rd;
    regwrite_q[0] <= issue_regwrite;
    load_q[0]     <= issue_load;
    if (rst) begin
      valid_q <= '0;
    end
  end

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] fwd_cnt_q;
  logic        fwd_event;

  assign fwd_event = !stall && issue_valid && !flush && ((fwd_a != '0) || (fwd_b != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (fwd_event && (fwd_cnt_q != 16'hFFFF)) begin
        fwd_cnt_q <= fwd_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic       issue_regwrite;
  logic       issue_load;
  logic [4:0] src_a;
  logic [4:0] src_b;
  logic       src_a_used;
  logic       src_b_used;
  logic       flush;

  logic        stall0, stall1;
  logic [1:0]  fa0, fb0;
  logic [2:0]  fa1, fb1;
  logic [15:0] sc0, fc0, sc1, fc1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_load(issue_load), .src_a(src_a), .src_b(src_b),
    .src_a_used(src_a_used), .src_b_used(src_b_used), .flush(flush), .stall(stall0),
    .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(sc0), .fwd_cnt(fc0)
  );

  hazard_scoreboard #(.DEPTH(5), .LOAD_STAGE(4)) dut5 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_load(issue_load), .src_a(src_a), .src_b(src_b),
    .src_a_used(src_a_used), .src_b_used(src_b_used), .flush(flush), .stall(stall1),
    .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(sc1), .fwd_cnt(fc1)
  );

  // Reference model: list of in-flight instructions, position k = k cycles past decode.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
  } ent_t;

  ent_t        m  [2][8];
  int unsigned ms [2];
  int unsigned mf [2];

  function automatic int dep(int c);
    return (c == 0) ? 3 : 5;
  endfunction

  function automatic int lst(int c);
    return (c == 0) ? 2 : 4;
  endfunction

  function automatic int exp_fwd(int c, logic [4:0] s, logic used);
    if (!used || s == 5'd31) return 0;
    for (int k = 1; k <= dep(c); k++) begin
      if (m[c][k].v && m[c][k].rw && m[c][k].rd == s) return k;
    end
    return 0;
  endfunction

  function automatic bit exp_stall(int c);
    int ka = exp_fwd(c, src_a, src_a_used);
    int kb = exp_fwd(c, src_b, src_b_used);
    bit h  = (ka != 0 && ka < lst(c) && m[c][ka].ld) || (kb != 0 && kb < lst(c) && m[c][kb].ld);
    return h && issue_valid && !flush;
  endfunction

  function automatic int exp_cnt(int n);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic model_clk();
    for (int c = 0; c < 2; c++) begin
      bit st  = exp_stall(c);
      bit fwd = (exp_fwd(c, src_a, src_a_used) != 0) || (exp_fwd(c, src_b, src_b_used) != 0);
      if (rst) begin
        for (int k = 1; k < 8; k++) m[c][k].v = 1'b0;
        ms[c] = 0;
        mf[c] = 0;
      end else begin
        if (st && ms[c] < 65535) ms[c]++;
        if (!st && issue_valid && !flush && fwd && mf[c] < 65535) mf[c]++;
        for (int k = 7; k > 1; k--) m[c][k] = m[c][k-1];
        m[c][1].v  = issue_valid && !st && !flush;
        m[c][1].rd = issue_rd;
        m[c][1].rw = issue_regwrite;
        m[c][1].ld = issue_load;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic set_in(input bit iv, input int rd, input bit rw, input bit ld, input int a,
                        input bit au, input int b, input bit bu, input bit fl);
    issue_valid = iv; issue_rd = 5'(rd); issue_regwrite = rw; issue_load = ld;
    src_a = 5'(a); src_a_used = au; src_b = 5'(b); src_b_used = bu; flush = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1, 4, 1, 1, 4, 1, 4, 1, 0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0d expected 0", stall0); end
    checks++; if (fa0 !== 2'd0 || fb0 !== 2'd0) begin failures++; $display("FAIL reset_fwd: got %0d/%0d expected 0/0", fa0, fb0); end
    checks++; if (sc0 !== 16'd0 || fc0 !== 16'd0) begin failures++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", sc0, fc0); end
    checks++; if (stall1 !== 1'b0 || sc1 !== 16'd0 || fc1 !== 16'd0) begin failures++; $display("FAIL reset_dut5: got stall=%0d cnt=%0d/%0d expected 0", stall1, sc1, fc1); end
  endtask

  task automatic test_alu_forward();
    do_reset();
    set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);   // ADD X1
    tick();
    set_in(1, 2, 1, 0, 1, 1, 3, 1, 0);   // SUB X2,X1,X3
    #1;
    checks++; if (fa0 !== 2'd1 || stall0 !== 1'b0) begin failures++; $display("FAIL alu_fwd: got fwd_a=%0d stall=%0d expected 1/0", fa0, stall0); end
    checks++; if (fb0 !== 2'd0) begin failures++; $display("FAIL alu_fwd_b: got %0d expected 0", fb0); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1, 4, 1, 1, 0, 0, 0, 0, 0);   // LDUR X4
    tick();
    set_in(1, 5, 1, 0, 4, 1, 4, 1, 0);   // ADD X5,X4,X4
    #1;
    checks++; if (stall0 !== 1'b1) begin failures++; $display("FAIL load_use_stall: got %0d expected 1", stall0); end
    tick();
    #1;
    checks++; if (stall0 !== 1'b0 || fa0 !== 2'd2 || fb0 !== 2'd2) begin failures++; $display("FAIL load_use_release: got stall=%0d fwd=%0d/%0d expected 0/2/2", stall0, fa0, fb0); end
    tick();
    idle();
    #1;
    checks++; if (sc0 !== 16'(exp_cnt(1)) || fc0 !== 16'(exp_cnt(1))) begin failures++; $display("FAIL load_use_cnt: got %0d/%0d expected %0d/%0d", sc0, fc0, exp_cnt(1), exp_cnt(1)); end
  endtask

  task automatic test_youngest();
    do_reset();
    set_in(1, 7, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 9, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 7, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 10, 1, 0, 3, 1, 7, 1, 0);
    #1;
    checks++; if (fb0 !== 2'd1 || stall0 !== 1'b0) begin failures++; $display("FAIL youngest: got fwd_b=%0d stall=%0d expected 1/0", fb0, stall0); end
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_in(1, 31, 1, 1, 0, 0, 0, 0, 0);  // load into X31
    tick();
    set_in(1, 2, 1, 0, 31, 1, 31, 1, 0);
    #1;
    checks++; if (fa0 !== 2'd0 || fb0 !== 2'd0 || stall0 !== 1'b0) begin failures++; $display("FAIL zero_reg: got fwd=%0d/%0d stall=%0d expected 0/0/0", fa0, fb0, stall0); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1, 4, 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 5, 1, 0, 4, 1, 0, 0, 1);   // consumer killed in the hazard cycle
    #1;
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL flush_stall: got %0d expected 0", stall0); end
    tick();
    set_in(1, 6, 1, 0, 5, 1, 4, 1, 0);   // X5 must not be in flight; load now at stage 2
    #1;
    checks++; if (fa0 !== 2'd0 || fb0 !== 2'd2 || stall0 !== 1'b0) begin failures++; $display("FAIL flush_bubble: got fwd=%0d/%0d stall=%0d expected 0/2/0", fa0, fb0, stall0); end
    checks++; if (sc0 !== 16'd0) begin failures++; $display("FAIL flush_cnt: got %0d expected 0", sc0); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_in(1, 4, 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 5, 1, 0, 4, 1, 0, 0, 0);
    #1;
    checks++; if (stall0 !== 1'b1) begin failures++; $display("FAIL mid_stall_pre: got %0d expected 1", stall0); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (stall0 !== 1'b0 || fa0 !== 2'd0) begin failures++; $display("FAIL mid_stall_reset: got stall=%0d fwd_a=%0d expected 0/0", stall0, fa0); end
    tick();
  endtask

  task automatic test_depth5();
    int n = 0;
    do_reset();
    set_in(1, 4, 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 5, 1, 0, 4, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!stall1) break;
      n++;
      tick();
    end
    checks++; if (n !== 3) begin failures++; $display("FAIL depth5_stalls: got %0d expected 3", n); end
    checks++; if (fa1 !== 3'd4 || stall1 !== 1'b0) begin failures++; $display("FAIL depth5_fwd: got fwd_a=%0d stall=%0d expected 4/0", fa1, stall1); end
    tick();
    idle();
    #1;
    checks++; if (sc1 !== 16'(exp_cnt(3)) || fc1 !== 16'(exp_cnt(1))) begin failures++; $display("FAIL depth5_cnt: got %0d/%0d expected %0d/%0d", sc1, fc1, exp_cnt(3), exp_cnt(1)); end
  endtask

  function automatic int rreg();
    int t = int'($urandom_range(0, 4));
    return (t == 4) ? 31 : t + 1;
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      set_in($urandom_range(0, 3) != 0, rreg(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             rreg(), $urandom_range(0, 3) != 0, rreg(), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7) == 0);
      #1;
      checks++; if (stall0 !== 1'(exp_stall(0)) || fa0 !== 2'(exp_fwd(0, src_a, src_a_used)) || fb0 !== 2'(exp_fwd(0, src_b, src_b_used))) begin
        failures++; $display("FAIL rand_d3 cyc %0d: got stall=%0d fwd=%0d/%0d expected %0d/%0d/%0d", i, stall0, fa0, fb0, exp_stall(0), exp_fwd(0, src_a, src_a_used), exp_fwd(0, src_b, src_b_used));
      end
      checks++; if (stall1 !== 1'(exp_stall(1)) || fa1 !== 3'(exp_fwd(1, src_a, src_a_used)) || fb1 !== 3'(exp_fwd(1, src_b, src_b_used))) begin
        failures++; $display("FAIL rand_d5 cyc %0d: got stall=%0d fwd=%0d/%0d expected %0d/%0d/%0d", i, stall1, fa1, fb1, exp_stall(1), exp_fwd(1, src_a, src_a_used), exp_fwd(1, src_b, src_b_used));
      end
      tick();
      checks++; if (sc0 !== 16'(exp_cnt(int'(ms[0]))) || fc0 !== 16'(exp_cnt(int'(mf[0]))) || sc1 !== 16'(exp_cnt(int'(ms[1]))) || fc1 !== 16'(exp_cnt(int'(mf[1])))) begin
        failures++; $display("FAIL rand_cnt cyc %0d: got %0d/%0d %0d/%0d expected %0d/%0d %0d/%0d", i, sc0, fc0, sc1, fc1, exp_cnt(int'(ms[0])), exp_cnt(int'(mf[0])), exp_cnt(int'(ms[1])), exp_cnt(int'(mf[1])));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_alu_forward();
    test_load_use();
    test_youngest();
    test_zero_reg();
    test_flush();
    test_reset_mid_stall();
    test_depth5();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_BITS, default 5: width of register specifiers.
REQ-002 SHALL have parameter DEPTH, default 3: number of tracked stages after decode (1=EX, 2=MEM, 3=WB); legal range 1..7.
REQ-003 SHALL have parameter LOAD_STAGE, default 2: first stage whose load result is forwardable; legal range 1..DEPTH.
REQ-004 SHALL have parameter ZERO_REG, default 31: hardwired-zero register, never tracked or forwarded.
REQ-005 SHALL provide one clock and a synchronous active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port issue_valid, input, 1 bit: decode-stage instruction is valid.
REQ-009 SHALL have port issue_rd, input, REG_BITS: destination register of the decode-stage instruction.
REQ-010 SHALL have port issue_regwrite, input, 1 bit: the decode-stage instruction writes issue_rd.
REQ-011 SHALL have port issue_load, input, 1 bit: the decode-stage instruction is a load.
REQ-012 SHALL have ports src_a and src_b, input, REG_BITS each: decode-stage source registers.
REQ-013 SHALL have ports src_a_used and src_b_used, input, 1 bit each: the matching source is actually read.
REQ-014 SHALL have port flush, input, 1 bit: kill the decode-stage instruction (taken branch).
REQ-015 SHALL have port stall, output, 1 bit: hold PC and IF/ID, and insert a bubble.
REQ-016 SHALL have ports fwd_a and fwd_b, output, FW = $clog2(DEPTH+1) each: 0 selects the regfile, k selects stage k.
REQ-017 SHALL have ports stall_cnt and fwd_cnt, output, 16 bits each: statistics counters (see Configuration).

Function
REQ-018 SHALL keep per-stage entries {valid, rd, regwrite, load} for stages 1..DEPTH.
REQ-019 SHALL shift entries each cycle: stage k <= stage k-1 for k=2..DEPTH; the stage DEPTH entry is discarded.
REQ-020 SHALL load stage 1 with the issue fields when issue_valid & ~stall & ~flush, and with a bubble (valid=0) otherwise.
REQ-021 SHALL treat stage k as matching source s when valid & regwrite & rd==s & rd!=ZERO_REG & s_used.
REQ-022 SHALL drive fwd_x with the lowest-index matching stage k, or 0 if no stage matches; the youngest producer wins.
REQ-023 SHALL raise the hazard condition when either source's youngest match is at stage k < LOAD_STAGE and that entry has load=1.
REQ-024 SHALL assert stall = hazard & issue_valid & ~flush, combinationally from the current state and inputs.
REQ-025 SHALL give flush priority over stall: on simultaneous flush and hazard, stall=0 and a bubble enters stage 1.
REQ-026 SHALL produce a load-use stall of exactly LOAD_STAGE-k cycles, because the bubble advances the load one stage per cycle.
REQ-027 SHALL keep fwd_a and fwd_b valid during stall; the consumer ignores them while stall=1.
REQ-028 SHALL never forward when src equals ZERO_REG, even if a stage targets ZERO_REG.

Reset
REQ-029 SHALL clear all stage valid bits on the cycle rst is sampled high, after which stall=0, fwd_a=0, fwd_b=0, stall_cnt=0 and fwd_cnt=0.
REQ-030 SHALL let reset asserted mid-stall clear the stall on the next edge; the pending instruction is dropped.

Configuration
REQ-031 SHALL compile the counters only when macro HAZARD_SCOREBOARD_STATS_EN is defined.
REQ-032 SHALL, with HAZARD_SCOREBOARD_STATS_EN defined, increment stall_cnt every cycle stall=1, and increment fwd_cnt every cycle stall=0 & issue_valid & ~flush & (fwd_a!=0 | fwd_b!=0).
REQ-033 SHALL saturate both counters at 16'hFFFF.
REQ-034 SHALL, without HAZARD_SCOREBOARD_STATS_EN, tie stall_cnt and fwd_cnt to 0 and instantiate no counter flops.

Verification
REQ-035 SHALL cover ADD X1 then SUB X2,X1,X3 (src_a=1) the next cycle -> fwd_a=1, stall=0.
REQ-036 SHALL cover LDUR X4 then ADD X5,X4,X4 back-to-back, defaults -> stall=1 for exactly 1 cycle, then fwd_a=fwd_b=2.
REQ-037 SHALL cover X7 written at stages 1 and 3 with src_b=7 -> fwd_b=1 (youngest wins).
REQ-038 SHALL cover a write to X31 followed by a read of src_a=31 -> fwd_a=0, stall=0.
REQ-039 SHALL cover load-use hazard with flush=1 in the same cycle -> stall=0, stage 1 bubble, no stall_cnt increment.
REQ-040 SHALL cover DEPTH=5 with LOAD_STAGE=4 and a load followed by its consumer -> 3 stall cycles, then fwd=4; with HAZARD_SCOREBOARD_STATS_EN, stall_cnt=3 and fwd_cnt=1.
